ibex_pmp_arb: RTL and testbench

IBEX_PMP_ARB -- requirements
Module: ibex_pmp_arb

---
 rtl/ibex_pmp_arb.sv | 120 ++++++++++++
 tb/tb_ibex_pmp_arb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_pmp_arb.sv
// Round-robin arbiter that shares one PMP check channel among several requesters,
// with a two-stage pipeline and a quiesce handshake for PMP configuration updates.
module ibex_pmp_arb #(
  parameter int NumReq = 2,
  parameter int AddrW  = 34
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic [NumReq*AddrW-1:0] req_addr_i,
  input  logic [NumReq*2-1:0]     req_type_i,
  input  logic [NumReq*2-1:0]     req_priv_i,
  output logic [NumReq-1:0]       rsp_valid_o,
  output logic                    rsp_err_o,
  output logic [AddrW-1:0]        chk_addr_o,
  output logic [1:0]              chk_type_o,
  output logic [1:0]              chk_priv_o,
  input  logic                    chk_err_i,
  input  logic                    cfg_upd_req_i,
  output logic                    cfg_upd_ack_o
);

  localparam int IdxW = (NumReq > 2) ? 2 : 1;

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]      state_reg, state_next;
  logic [IdxW-1:0] ptr_reg, ptr_next;
  logic [IdxW-1:0] grant_idx, cand_idx;
  logic            grant_any, accept;

  logic             s1_valid_reg;
  logic [IdxW-1:0]  s1_idx_reg;
  logic [AddrW-1:0] s1_addr_reg;
  logic [1:0]       s1_type_reg, s1_priv_reg;

  logic             s2_valid_reg;
  logic [IdxW-1:0]  s2_idx_reg;
  logic             s2_err_reg;

  logic [AddrW-1:0] addr_arr [NumReq];
  logic [1:0]       type_arr [NumReq];
  logic [1:0]       priv_arr [NumReq];

  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr_i[gi*AddrW +: AddrW];
      assign type_arr[gi] = req_type_i[gi*2 +: 2];
      assign priv_arr[gi] = req_priv_i[gi*2 +: 2];
    end
  endgenerate

  // Scan downwards so the candidate nearest the pointer is the last one to win.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      cand_idx = IdxW'((int'(ptr_reg) + k) % NumReq);
      if (req_valid_i[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign accept      = grant_any && (state_reg == RUN) && rst_ni && !cfg_upd_req_i;
  assign req_ready_o = accept ? (NumReq'(1) << grant_idx) : '0;
  assign ptr_next    = (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (cfg_upd_req_i) state_next = s1_valid_reg ? DRAIN : HOLD;
      DRAIN:   if (!s1_valid_reg) state_next = HOLD;
      HOLD:    if (!cfg_upd_req_i) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg    <= RUN;
      ptr_reg      <= '0;
      s1_valid_reg <= 1'b0;
      s1_idx_reg   <= '0;
      s1_addr_reg  <= '0;
      s1_type_reg  <= '0;
      s1_priv_reg  <= '0;
      s2_valid_reg <= 1'b0;
      s2_idx_reg   <= '0;
      s2_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      s1_valid_reg <= accept;
      if (accept) begin
        ptr_reg     <= ptr_next;
        s1_idx_reg  <= grant_idx;
        s1_addr_reg <= addr_arr[grant_idx];
        s1_type_reg <= type_arr[grant_idx];
        s1_priv_reg <= priv_arr[grant_idx];
      end
      // The checker result belongs to whatever S1 presents this cycle.
      s2_valid_reg <= s1_valid_reg;
      s2_idx_reg   <= s1_idx_reg;
      s2_err_reg   <= chk_err_i;
    end
  end

  assign chk_addr_o    = s1_valid_reg ? s1_addr_reg : '0;
  assign chk_type_o    = s1_valid_reg ? s1_type_reg : '0;
  assign chk_priv_o    = s1_valid_reg ? s1_priv_reg : '0;
  assign rsp_valid_o   = s2_valid_reg ? (NumReq'(1) << s2_idx_reg) : '0;
  assign rsp_err_o     = s2_valid_reg && s2_err_reg;
  assign cfg_upd_ack_o = (state_reg == HOLD);

endmodule

// File: tb/tb_ibex_pmp_arb.sv
// Randomised bench for ibex_pmp_arb: a queue-based model of in-flight checks,
// directed literal scenarios first, then a long random run.
module tb_ibex_pmp_arb;
  localparam int N  = 2;
  localparam int AW = 34;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    valid;
  logic [N-1:0]    ready;
  logic [N*AW-1:0] addr_bus;
  logic [N*2-1:0]  type_bus, priv_bus;
  logic [N-1:0]    rsp_valid;
  logic            rsp_err;
  logic [AW-1:0]   chk_addr;
  logic [1:0]      chk_type, chk_priv;
  logic            chk_err;
  logic            cfg;
  logic            ack;

  always #5 clk = ~clk;

  ibex_pmp_arb #(.NumReq(N), .AddrW(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid), .req_ready_o(ready),
    .req_addr_i(addr_bus), .req_type_i(type_bus), .req_priv_i(priv_bus),
    .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err),
    .chk_addr_o(chk_addr), .chk_type_o(chk_type), .chk_priv_o(chk_priv),
    .chk_err_i(chk_err),
    .cfg_upd_req_i(cfg), .cfg_upd_ack_o(ack)
  );

  typedef struct {
    int          idx;
    logic [AW-1:0] addr;
    logic [1:0]  typ;
    logic [1:0]  priv;
    int          acc;
    bit          err;
  } ent_t;

  ent_t fl[$];
  int   m_mode;      // 0 running, 1 draining, 2 holding
  int   m_ptr;
  int   m_g;
  int   s1i, s2i;
  int   cyc;
  int   vectors = 0;
  int   misc = 0;

  bit            pending [N];
  logic [AW-1:0] p_addr [N];
  logic [1:0]    p_type [N];
  logic [1:0]    p_priv [N];

  function automatic bit fault(logic [AW-1:0] a, logic [1:0] t, logic [1:0] p);
    return a[8] ^ a[2] ^ t[0] ^ p[1];
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      valid[i]            = pending[i];
      addr_bus[i*AW +: AW] = p_addr[i];
      type_bus[i*2 +: 2]  = p_type[i];
      priv_bus[i*2 +: 2]  = p_priv[i];
    end
  endtask

  // Predict this cycle's outputs, feed the checker, compare.
  task automatic settle_check();
    logic [N-1:0]  e_ready, e_rsp;
    logic [AW-1:0] e_addr;
    logic [1:0]    e_type, e_priv;
    bit            e_err;
    drive();
    #1;
    m_g = -1;
    if (rst_n && m_mode == 0 && !cfg)
      for (int k = 0; k < N; k++)
        if (m_g < 0 && valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
    e_ready = '0;
    if (m_g >= 0) e_ready[m_g] = 1'b1;
    s1i = -1; s2i = -1;
    foreach (fl[q]) begin
      if (fl[q].acc == cyc - 1) s1i = q;
      if (fl[q].acc == cyc - 2) s2i = q;
    end
    e_addr = '0; e_type = '0; e_priv = '0;
    if (s1i >= 0) begin
      e_addr = fl[s1i].addr; e_type = fl[s1i].typ; e_priv = fl[s1i].priv;
      fl[s1i].err = fault(e_addr, e_type, e_priv);
    end
    chk_err = fault(e_addr, e_type, e_priv);
    e_rsp = '0; e_err = 1'b0;
    if (s2i >= 0) begin
      e_rsp[fl[s2i].idx] = 1'b1;
      e_err = fl[s2i].err;
    end
    #1;
    chk("ready", 64'(ready), 64'(e_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
    chk("rsp_err", 64'(rsp_err), 64'(e_err));
    chk("chk_addr", 64'(chk_addr), 64'(e_addr));
    chk("chk_type", 64'(chk_type), 64'(e_type));
    chk("chk_priv", 64'(chk_priv), 64'(e_priv));
    chk("ack", 64'(ack), 64'(m_mode == 2));
  endtask

  task automatic commit();
    ent_t e;
    if (!rst_n) begin
      fl.delete();
      m_mode = 0;
      m_ptr  = 0;
    end else begin
      case (m_mode)
        0: begin
          if (cfg) m_mode = (s1i >= 0) ? 1 : 2;
          else if (m_g >= 0) begin
            e.idx = m_g; e.addr = p_addr[m_g]; e.typ = p_type[m_g];
            e.priv = p_priv[m_g]; e.acc = cyc; e.err = 1'b0;
            fl.push_back(e);
            m_ptr = (m_g + 1) % N;
            pending[m_g] = 1'b0;
          end
        end
        1: if (s1i < 0) m_mode = 2;
        default: if (!cfg) m_mode = 0;
      endcase
      while (fl.size() > 0 && fl[0].acc <= cyc - 2) void'(fl.pop_front());
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Directed cycle with literal expectations; -1 skips a literal.
  task automatic dcyc(bit r, bit c, logic [N-1:0] v, logic [N-1:0] er,
                      logic [N-1:0] ersp, bit eack, longint echk, int eerr);
    rst_n = r;
    cfg   = c;
    for (int i = 0; i < N; i++) pending[i] = v[i];
    settle_check();
    chk("lit_ready", 64'(ready), 64'(er));
    chk("lit_rsp", 64'(rsp_valid), 64'(ersp));
    chk("lit_ack", 64'(ack), 64'(eack));
    if (echk >= 0) chk("lit_chk_addr", 64'(chk_addr), 64'(echk));
    if (eerr >= 0) chk("lit_rsp_err", 64'(rsp_err), 64'(eerr));
    commit();
  endtask

  initial begin
    cyc = 0; m_mode = 0; m_ptr = 0;
    rst_n = 1'b0; cfg = 1'b0; chk_err = 1'b0;
    p_addr[0] = 34'h100; p_type[0] = 2'b10; p_priv[0] = 2'b00;
    p_addr[1] = 34'h204; p_type[1] = 2'b01; p_priv[1] = 2'b11;
    for (int i = 0; i < N; i++) pending[i] = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;

    // reset holds ready low even with valid requests
    dcyc(0, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0);
    // single request, latency two, checker fault returned
    dcyc(1, 0, 2'b01, 2'b01, 2'b00, 0, -1, -1);
    dcyc(1, 0, 2'b00, 2'b00, 2'b00, 0, 34'h100, -1);
    dcyc(1, 0, 2'b00, 2'b00, 2'b01, 0, 0, 1);
    dcyc(0, 0, 2'b00, 2'b00, 2'b00, 0, -1, -1);
    // contention from reset
    dcyc(1, 0, 2'b11, 2'b01, 2'b00, 0, -1, -1);
    dcyc(1, 0, 2'b11, 2'b10, 2'b00, 0, -1, -1);
    dcyc(1, 0, 2'b11, 2'b01, 2'b01, 0, -1, -1);
    dcyc(1, 0, 2'b11, 2'b10, 2'b10, 0, -1, -1);
    dcyc(1, 0, 2'b00, 2'b00, 2'b01, 0, -1, -1);
    dcyc(1, 0, 2'b00, 2'b00, 2'b10, 0, -1, -1);
    // back-to-back on requester 1
    dcyc(1, 0, 2'b10, 2'b10, 2'b00, 0, -1, -1);
    dcyc(1, 0, 2'b10, 2'b10, 2'b00, 0, -1, -1);
    dcyc(1, 0, 2'b10, 2'b10, 2'b10, 0, -1, -1);
    dcyc(1, 0, 2'b00, 2'b00, 2'b10, 0, -1, -1);
    dcyc(1, 0, 2'b00, 2'b00, 2'b10, 0, -1, -1);
    // quiesce with one check in flight
    dcyc(1, 0, 2'b01, 2'b01, 2'b00, 0, -1, -1);
    dcyc(1, 1, 2'b01, 2'b00, 2'b00, 0, -1, -1);
    dcyc(1, 1, 2'b01, 2'b00, 2'b01, 0, 0, -1);
    dcyc(1, 1, 2'b01, 2'b00, 2'b00, 1, -1, -1);
    dcyc(1, 0, 2'b01, 2'b00, 2'b00, 1, -1, -1);
    dcyc(1, 0, 2'b01, 2'b01, 2'b00, 0, -1, -1);
    dcyc(1, 0, 2'b00, 2'b00, 2'b00, 0, -1, -1);
    dcyc(1, 0, 2'b00, 2'b00, 2'b01, 0, -1, -1);
    // reset the cycle after an accept: no response, pointer back to 0
    dcyc(1, 0, 2'b01, 2'b01, 2'b00, 0, -1, -1);
    dcyc(0, 0, 2'b11, 2'b00, 2'b00, 0, -1, -1);
    dcyc(1, 0, 2'b11, 2'b01, 2'b00, 0, 0, -1);
    dcyc(1, 0, 2'b00, 2'b00, 2'b00, 0, -1, -1);
    dcyc(1, 0, 2'b00, 2'b00, 2'b01, 0, -1, -1);
    // quiesce when idle
    dcyc(1, 1, 2'b00, 2'b00, 2'b00, 0, -1, -1);
    dcyc(1, 1, 2'b00, 2'b00, 2'b00, 1, -1, -1);
    dcyc(1, 0, 2'b00, 2'b00, 2'b00, 1, -1, -1);
    dcyc(1, 0, 2'b00, 2'b00, 2'b00, 0, -1, -1);

    for (int t = 0; t < 3000; t++) begin
      rst_n = ($urandom_range(299) != 0);
      if (cfg ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0)) cfg = ~cfg;
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(2) == 0) begin
          pending[i] = 1'b1;
          p_addr[i]  = {$urandom(), $urandom()};
          p_type[i]  = 2'($urandom_range(2));
          p_priv[i]  = 2'($urandom_range(3));
        end
      end
      settle_check();
      commit();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end
endmodule
